// File: rtl/multicycle_control_fsm.sv
// Main sequencing controller for the multicycle MIPS datapath: one state per
// datapath step, control outputs decoded from the current state.
module multicycle_control_fsm #(
   parameter int ENABLE_BNE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_control,
   output logic [3:0] state,
   output logic       illegal_op
);

   // state  | meaning
   // FETCH  | read instruction at PC, PC <= PC + 4
   // DECODE | branch target into ALUOut, dispatch on opcode
   // MEMADR | effective address for lw/sw
   // MEMRD  | data memory read
   // MEMWB  | load data into rt
   // MEMWR  | data memory write
   // EXEC   | R-type ALU operation
   // ALUWB  | R-type result into rd
   // BRANCH | compare registers, conditional PC <= ALUOut
   // ADDIEX | A + immediate
   // ADDIWB | addi result into rt
   // JUMP   | PC <= jump target
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic BNE_ON = (ENABLE_BNE != 0);

   state_t     r_state;
   state_t     w_state_next;
   state_t     w_dec_state;
   logic       w_pc_write;
   logic       w_branch;
   logic       w_branch_cond;
   logic       w_illegal;
   logic [1:0] w_aluop;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_state_next;
   end

   // While reset is held the datapath sees FETCH controls with all writes off.
   always_comb begin
      w_state_next = S_FETCH;
      w_dec_state  = reset ? S_FETCH : r_state;
      w_pc_write   = 1'b0;
      w_branch     = 1'b0;
      w_illegal    = 1'b0;
      w_aluop      = ALUOP_ADD;
      iord         = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      mem_to_reg   = 1'b0;
      reg_dst      = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      pc_src       = 2'b00;
      case (w_dec_state)
         S_FETCH: begin
            alu_src_b    = 2'b01;
            ir_write     = 1'b1;
            w_pc_write   = 1'b1;
            w_state_next = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_LW, OP_SW: w_state_next = S_MEMADR;
               OP_RTYPE:     w_state_next = S_EXEC;
               OP_BEQ:       w_state_next = S_BRANCH;
               OP_BNE: begin
                  if (BNE_ON) w_state_next = S_BRANCH;
                  else        w_illegal    = 1'b1;
               end
               OP_ADDI:      w_state_next = S_ADDIEX;
               OP_J:         w_state_next = S_JUMP;
               default:      w_illegal    = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'b10;
            w_state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord         = 1'b1;
            w_state_next = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_EXEC: begin
            alu_src_a    = 1'b1;
            w_aluop      = ALUOP_FUNCT;
            w_state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            w_aluop   = ALUOP_SUB;
            pc_src    = 2'b01;
            w_branch  = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'b10;
            w_state_next = S_ADDIWB;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_JUMP: begin
            pc_src     = 2'b10;
            w_pc_write = 1'b1;
         end
         default: w_state_next = S_FETCH;
      endcase
      if (reset) begin
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         w_pc_write = 1'b0;
         w_branch   = 1'b0;
         w_illegal  = 1'b0;
      end
   end

   always_comb begin
      w_branch_cond = 1'b0;
      if (op == OP_BEQ)               w_branch_cond = zero;
      else if (BNE_ON && op == OP_BNE) w_branch_cond = ~zero;
      pc_en = w_pc_write | (w_branch & w_branch_cond);
   end

   // Unknown funct codes fall back to add and still write back.
   always_comb begin
      alu_control = 3'b010;
      case (w_aluop)
         ALUOP_SUB: alu_control = 3'b110;
         ALUOP_FUNCT: begin
            case (funct)
               6'b100010: alu_control = 3'b110;
               6'b100100: alu_control = 3'b000;
               6'b100101: alu_control = 3'b001;
               6'b101010: alu_control = 3'b111;
               default:   alu_control = 3'b010;
            endcase
         end
         default: alu_control = 3'b010;
      endcase
   end

   assign state      = r_state;
   assign illegal_op = w_illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: a per-instruction reference
// model queues expected control vectors, a negedge monitor compares them.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic [3:0] state;
   logic       illegal_op;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_en;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_control;
      logic       illegal_op;
   } ctl_t;

   typedef struct {
      ctl_t  v;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   stim_done = 1'b0;

   multicycle_control_fsm #(.ENABLE_BNE(1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_control(alu_control), .state(state), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // Sequence of states an instruction visits, starting at FETCH.
   function automatic void state_seq(input logic [5:0] o, output int seq[$]);
      case (o)
         6'b100011: seq = '{0, 1, 2, 3, 4};
         6'b101011: seq = '{0, 1, 2, 5};
         6'b000000: seq = '{0, 1, 6, 7};
         6'b001000: seq = '{0, 1, 9, 10};
         6'b000100, 6'b000101: seq = '{0, 1, 8};
         6'b000010: seq = '{0, 1, 11};
         default:   seq = '{0, 1};
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic bit op_legal(input logic [5:0] o);
      int s[$];
      state_seq(o, s);
      return s.size() > 2;
   endfunction

   function automatic ctl_t model(input int st, input logic [5:0] o, input logic [5:0] f,
                                  input logic z);
      ctl_t v = '0;
      v.st = st[3:0];
      v.alu_control = 3'b010;
      case (st)
         0: begin v.alu_src_b = 2'b01; v.ir_write = 1; v.pc_en = 1; end
         1: begin v.alu_src_b = 2'b11; v.illegal_op = !op_legal(o); end
         2: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         3: v.iord = 1;
         4: begin v.mem_to_reg = 1; v.reg_write = 1; end
         5: begin v.iord = 1; v.mem_write = 1; end
         6: begin v.alu_src_a = 1; v.alu_control = funct_alu(f); end
         7: begin v.reg_dst = 1; v.reg_write = 1; end
         8: begin
            v.alu_src_a = 1; v.alu_control = 3'b110; v.pc_src = 2'b01;
            v.pc_en = (o == 6'b000100) ? z : ~z;
         end
         9: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         10: v.reg_write = 1;
         11: begin v.pc_src = 2'b10; v.pc_en = 1; end
         default: ;
      endcase
      return v;
   endfunction

   function automatic ctl_t reset_model(input int st);
      ctl_t v = model(0, 6'b0, 6'b0, 1'b0);
      v.st = st[3:0];
      v.pc_en = 0;
      v.ir_write = 0;
      return v;
   endfunction

   task automatic push(input ctl_t v, input string tag);
      exp_t e;
      e.v = v;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // abort_at >= 0 asserts reset during that step of the instruction.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int abort_at, input string tag);
      int seq[$];
      state_seq(o, seq);
      for (int k = 0; k < seq.size(); k++) begin
         @(posedge clk); #1;
         reset = 1'b0;
         op = o; funct = f; zero = z;
         if (k == abort_at) begin
            reset = 1'b1;
            push(reset_model(seq[k]), {tag, "_rst"});
            return;
         end
         push(model(seq[k], o, f, z), $sformatf("%s_s%0d", tag, seq[k]));
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         ctl_t a;
         e = exp_q.pop_front();
         a = '{state, pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, pc_src, alu_control, illegal_op};
         checks++;
         if (a !== e.v) begin
            failures++;
            $display("FAIL %s t=%0t actual=%05h required=%05h (op=%b funct=%b zero=%b)",
                     e.tag, $time, a, e.v, op, funct, zero);
         end
      end
   end

   initial begin
      logic [5:0] legal_ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                    6'b000101, 6'b001000, 6'b000010};
      logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] ro, rf;
      reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
      @(posedge clk); #1;
      push(reset_model(0), "reset_c1");
      @(posedge clk); #1;
      push(reset_model(0), "reset_c2");

      run_instr(6'b100011, 6'b000000, 1'b0, -1, "lw");
      run_instr(6'b000000, 6'b101010, 1'b0, -1, "slt");
      run_instr(6'b000100, 6'b000000, 1'b1, -1, "beq_z1");
      run_instr(6'b000100, 6'b000000, 1'b0, -1, "beq_z0");
      run_instr(6'b000101, 6'b000000, 1'b1, -1, "bne_z1");
      run_instr(6'b000101, 6'b000000, 1'b0, -1, "bne_z0");
      run_instr(6'b101011, 6'b000000, 1'b0, -1, "sw");
      run_instr(6'b000010, 6'b000000, 1'b0, -1, "j");
      run_instr(6'b111111, 6'b000000, 1'b0, -1, "illegal");
      run_instr(6'b001000, 6'b000000, 1'b0, -1, "addi");
      run_instr(6'b000000, 6'b111111, 1'b0, -1, "rtype_badfunct");
      run_instr(6'b100011, 6'b000000, 1'b0, 3, "lw_abort");
      run_instr(6'b000000, 6'b100100, 1'b0, -1, "and_after_abort");

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 7) ro = legal_ops[$urandom_range(0, 6)];
         else                          ro = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 9) < 8) rf = functs[$urandom_range(0, 4)];
         else                          rf = 6'($urandom_range(0, 63));
         run_instr(ro, rf, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1,
                   $sformatf("rnd%0d", n));
      end
      @(posedge clk); #1;
      reset = 1'b0;
      stim_done = 1'b1;
   end

   initial begin
      int waited = 0;
      wait (stim_done);
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog timeout reached stim_done=%0b required=1", stim_done);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the multicycle MIPS datapath in `main`.
- Sequences fetch, decode, execute, memory and writeback. One instruction occupies 3-5 cycles.
- Drives every datapath mux select and write enable, plus the ALU function code.
- Takes the instruction opcode, funct field and the ALU zero flag as inputs.

Parameters:
- ENABLE_BNE, default 1: when 1, opcode 000101 (bne) is decoded as a branch taken on zero=0. When 0, bne is an illegal opcode.

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag, combinational, valid in the BEQ state
- pc_en  out  1  PC load enable = pc_write | (branch & branch_cond)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register load enable
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = Data register
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_control  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state encoding, for debug and waveform viewing
- illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported

Behaviour:
- Moore FSM with a 4-bit state register. All outputs are decoded combinationally from the state; pc_en, alu_control and illegal_op also depend on zero, funct or op as noted.
- Reset:
  - At a rising edge with reset=1, state <= FETCH (0).
  - While reset=1, pc_en, ir_write, mem_write, reg_write and illegal_op are forced to 0. Other outputs follow the FETCH decode.
  - A reset asserted mid-instruction aborts that instruction; no further writes occur.
- State encodings and per-state actions (any control not listed is 0; aluop selects the ALU function):
  - FETCH (0): iord=0, alu_src_a=0, alu_src_b=01, aluop=add, pc_src=00, ir_write=1, pc_write=1.
  - DECODE (1): alu_src_a=0, alu_src_b=11, aluop=add. Computes the branch target into ALUOut.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, aluop=add.
  - MEMRD (3): iord=1.
  - MEMWB (4): reg_dst=0, mem_to_reg=1, reg_write=1.
  - MEMWR (5): iord=1, mem_write=1.
  - EXEC (6): alu_src_a=1, alu_src_b=00, aluop=funct.
  - ALUWB (7): reg_dst=1, mem_to_reg=0, reg_write=1.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, aluop=sub, pc_src=01, branch=1. branch_cond = zero for beq, ~zero for bne.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, aluop=add.
  - ADDIWB (10): reg_dst=0, mem_to_reg=0, reg_write=1.
  - JUMP (11): pc_src=10, pc_write=1.
  - Encodings 12-15 are unused; they return to FETCH on the next edge with no writes.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq), or 000101 (bne) when ENABLE_BNE=1 -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other op -> FETCH, with illegal_op=1 for that DECODE cycle
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB. EXEC -> ALUWB. ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Latency in cycles, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal opcode 2.
- alu_control decode when aluop=funct:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - any other funct -> 010. The instruction still writes back; no fault is raised.
- pc_en is 1 in FETCH and JUMP. In BRANCH it is 1 only when branch_cond=1. It is 0 in every other state.
- Outputs never glitch on state change beyond normal combinational settling. Consumers sample only at clk rising edges.

Test Plan:
- Reset for 2 cycles, then release -> state=0 on the first post-reset cycle. While reset=1, pc_en, ir_write, mem_write and reg_write all read 0.
- op=100011 (lw) -> state sequence 0,1,2,3,4,0. Check iord=1 in state 3; mem_to_reg=1 and reg_write=1 in state 4; mem_write=0 throughout.
- op=000000 with funct=101010 (slt) -> states 0,1,6,7,0. alu_control=111 in state 6; reg_dst=1 and reg_write=1 in state 7.
- op=000100 (beq) with zero=1 -> pc_en=1, pc_src=01 in state 8. Repeat with zero=0 -> pc_en=0. With ENABLE_BNE=1 and op=000101, the polarity inverts.
- op=101011 (sw) -> states 0,1,2,5,0 with mem_write=1 only in state 5. Then op=000010 (j) -> states 0,1,11,0 with pc_src=10 and pc_en=1 in state 11.
- op=111111 -> illegal_op=1 for exactly one cycle in DECODE, then state 0, with no reg_write or mem_write. Separately, assert reset while in state 3 of a lw -> next state 0, and no MEMWB write occurs.
